// File: rtl/serial_mac_if.sv
// serial_mac_if: handshake/data bundle for serial_mac.
//   slave  (MAC side) : i_start, i_input_neuron, i_weight_bit, i_enable, i_clear_acc in;
//                       o_busy, o_done, o_out out
//   master (driver)   : the mirror image
interface serial_mac_if #(
  parameter int DATA_W = 16
);
  logic              i_start;
  logic [DATA_W-1:0] i_input_neuron;
  logic              i_weight_bit;
  logic              i_enable;
  logic              i_clear_acc;
  logic              o_busy;
  logic              o_done;
  logic [DATA_W-1:0] o_out;

  modport master (
    output i_start, i_input_neuron, i_weight_bit, i_enable, i_clear_acc,
    input  o_busy, o_done, o_out
  );
  modport slave (
    input  i_start, i_input_neuron, i_weight_bit, i_enable, i_clear_acc,
    output o_busy, o_done, o_out
  );
endinterface

// File: rtl/serial_mac.sv
// serial_mac: bit-serial signed multiply-accumulate.
//   A parallel signed neuron value is multiplied by a signed weight streamed
//   LSB first (one bit per enabled cycle), the product is added into a wide
//   accumulator and the Q-format result acc >>> FRAC_W is presented on o_out.
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous active-low reset
//   bus      - serial_mac_if.slave: start/operand/weight bit/enable/clear in,
//              busy/done/out back
// Build option: SERIAL_MAC_SAT_EN - saturate acc at ACC_W signed limits and
//   out at DATA_W signed limits; undefined means both wrap.
module serial_mac #(
  parameter int DATA_W   = 16,
  parameter int WEIGHT_W = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40
) (
  input  logic         i_clk,
  input  logic         i_reset,
  serial_mac_if.slave  bus
);
  localparam int CNT_W = $clog2(WEIGHT_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WEIGHT_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_ACC   = 2'd2;

  logic [1:0]        r_state;
  logic [ACC_W-1:0]  r_operand;
  logic [ACC_W-1:0]  r_partial;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_out;

  logic [ACC_W-1:0]  w_ext;
  logic [ACC_W-1:0]  w_term;
  logic [ACC_W-1:0]  w_partial_nxt;
  logic [ACC_W-1:0]  w_base;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [DATA_W-1:0] w_out_nxt;
  logic              w_last;

  assign w_ext  = {{(ACC_W-DATA_W){bus.i_input_neuron[DATA_W-1]}}, bus.i_input_neuron};
  assign w_last = (r_cnt == LAST);
  assign w_term = bus.i_weight_bit ? (r_operand << r_cnt) : '0;
  // The MSB of a two's-complement weight carries negative weight.
  assign w_partial_nxt = w_last ? (r_partial - w_term) : (r_partial + w_term);

  // clear_acc in the ACC cycle clears first, then adds this product.
  assign w_base = bus.i_clear_acc ? '0 : r_acc;
  assign w_sum  = w_base + r_partial;

`ifdef SERIAL_MAC_SAT_EN
  localparam logic [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic              w_ovf;
  logic              w_in_rng;
  logic [ACC_W-1:0]  w_shr;

  // Overflow only when both addends share a sign the sum does not.
  assign w_ovf     = (w_base[ACC_W-1] == r_partial[ACC_W-1]) &&
                     (w_sum[ACC_W-1]  != w_base[ACC_W-1]);
  assign w_acc_nxt = w_ovf ? (w_base[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum;
  assign w_shr     = $signed(w_acc_nxt) >>> FRAC_W;
  // In range when every bit above the out sign bit matches it.
  assign w_in_rng  = (&w_shr[ACC_W-1:DATA_W-1]) | ~(|w_shr[ACC_W-1:DATA_W-1]);
  assign w_out_nxt = w_in_rng ? w_shr[DATA_W-1:0] : (w_shr[ACC_W-1] ? OUT_MIN : OUT_MAX);
`else
  assign w_acc_nxt = w_sum;
  // Low DATA_W bits of acc >>> FRAC_W are just a bit-select of acc.
  assign w_out_nxt = w_acc_nxt[FRAC_W +: DATA_W];
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_operand <= '0;
      r_partial <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          // Bit 0 is taken on the start cycle; enable does not matter here.
          r_operand <= w_ext;
          r_partial <= bus.i_weight_bit ? w_ext : '0;
          r_cnt     <= CNT_W'(1);
          r_state   <= S_SHIFT;
        end
        S_SHIFT: if (bus.i_enable) begin
          r_partial <= w_partial_nxt;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_ACC;
        end
        S_ACC: begin
          r_acc   <= w_acc_nxt;
          r_out   <= w_out_nxt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (bus.i_clear_acc && r_state != S_ACC) r_acc <= '0;
    end
  end

  assign bus.o_busy = (r_state != S_IDLE);
  assign bus.o_done = (r_state == S_ACC);
  assign bus.o_out  = r_out;
endmodule
